// File: rtl/vinput_sched_pkg.sv
// vinput_sched_pkg: FSM states, width helpers and result entry type for the vinput sequencer
package vinput_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT_RD, ISSUE, GAP, DRAIN, DONE} state_t;
  function automatic int j_width(input int j);
    return $clog2(j) + 1;
  endfunction
  function automatic int a_width(input int a);
    return $clog2(a) + 1;
  endfunction
  localparam int DEF_J = 14;
  typedef struct packed {
    logic [j_width(DEF_J)-1:0] j;
    logic [63:0]               data;
  } res_entry_t;
endpackage

// File: rtl/vinput_sched_fifo.sv
// vinput_sched_fifo: synchronous first-word-fall-through FIFO with occupancy count
module vinput_sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int P = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [P:0]   wptr, rptr;
  logic         full, empty, do_wr, do_rd;
  // pointers carry one extra wrap bit so full and empty stay distinguishable
  assign full  = (wptr ^ rptr) == {1'b1, {P{1'b0}}};
  assign empty = wptr == rptr;
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign count = wptr - rptr;
  assign rdata = empty ? '0 : mem[rptr[P-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wptr[P-1:0]] <= wdata;
endmodule

// File: rtl/vinput_sched.sv
// vinput_sched: sequences backbone fetch/issue over j with spacing and credit control.
// Optional VSCHED_WATCHDOG_EN adds wdog_err and a stalled-datapath timeout.
module vinput_sched
  import vinput_sched_pkg::*;
#(
  parameter int J         = 14,
  parameter int A         = 2,
  parameter int MAX_OUT   = 8,
  parameter int ISSUE_GAP = 12,
  localparam int J_WIDTH  = j_width(J),
  localparam int A_WIDTH  = a_width(A),
  localparam int C_WIDTH  = $clog2(MAX_OUT) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [J*A_WIDTH-1:0]   cfg_x_initial,
  output logic                   busy,
  output logic                   done,
  output logic                   bb_rd_en,
  output logic [J_WIDTH-1:0]     bb_rd_addr,
  input  logic                   bb_rd_valid,
  input  logic [63:0]            bb_rd_data,
  output logic [J*A_WIDTH-1:0]   x_initial,
  output logic                   x_initial_tvalid,
  output logic [J_WIDTH-1:0]     ind_j,
  output logic                   ind_j_tvalid,
  output logic [63:0]            backbone,
  output logic                   backbone_tvalid,
  input  logic                   vinput_tvalid,
  input  logic [63:0]            vinput,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [63:0]            res_data,
  output logic [J_WIDTH-1:0]     res_j
`ifdef VSCHED_WATCHDOG_EN
  ,
  output logic                   wdog_err
`endif
);
  localparam int G_WIDTH = $clog2(ISSUE_GAP) + 1;
  state_t               state, nxt;
  logic [J_WIDTH-1:0]   j, tag;
  logic [G_WIDTH-1:0]   gap;
  logic [C_WIDTH-1:0]   in_flight, buf_count;
  logic [J_WIDTH+63:0]  head;
  logic                 err, ret, issue, last, credit_ok, wdog_trip;
  assign ret       = vinput_tvalid && in_flight != '0;
  assign issue     = state == ISSUE && gap == '0;
  assign last      = j == J_WIDTH'(J - 1);
  assign credit_ok = int'(in_flight) + int'(buf_count) < MAX_OUT;
  assign busy             = state != IDLE && state != DONE;
  assign done             = state == DONE;
  assign bb_rd_en         = state == FETCH && credit_ok;
  assign bb_rd_addr       = j;
  assign ind_j            = j;
  assign x_initial_tvalid = state == LOAD;
  assign backbone_tvalid  = issue;
  assign ind_j_tvalid     = issue;
  assign res_valid        = buf_count != '0;
  assign {res_j, res_data} = head;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = FETCH;
      FETCH:   nxt = credit_ok ? WAIT_RD : FETCH;
      WAIT_RD: nxt = bb_rd_valid ? ISSUE : WAIT_RD;
      ISSUE:   nxt = issue ? GAP : ISSUE;
      GAP:     nxt = last ? DRAIN : FETCH;
      DRAIN:   nxt = in_flight == '0 ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
    if (wdog_trip) nxt = DONE;
  end
  // gap keeps counting through FETCH/WAIT_RD; ISSUE holds until it expires
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      j         <= '0;
      gap       <= '0;
      x_initial <= '0;
      backbone  <= '0;
      err       <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) x_initial <= cfg_x_initial;
      if (state == LOAD) j <= '0;
      if (state == GAP && !last) j <= j + 1'b1;
      if (state == WAIT_RD && bb_rd_valid) backbone <= bb_rd_data;
      gap <= issue ? G_WIDTH'(ISSUE_GAP - 1) : (gap != '0 ? gap - 1'b1 : gap);
      if (vinput_tvalid && in_flight == '0) err <= 1'b1;
    end
  vinput_sched_fifo #(.W(J_WIDTH), .DEPTH(MAX_OUT)) u_tag (
    .clk(clk), .rst(rst), .wr(issue), .wdata(j), .rd(ret), .rdata(tag), .count(in_flight)
  );
  vinput_sched_fifo #(.W(J_WIDTH + 64), .DEPTH(MAX_OUT)) u_buf (
    .clk(clk), .rst(rst), .wr(ret), .wdata({tag, vinput}), .rd(res_valid && res_ready),
    .rdata(head), .count(buf_count)
  );
`ifdef VSCHED_WATCHDOG_EN
  logic [15:0] wd_cnt;
  assign wdog_trip = !wdog_err && in_flight != '0 && !vinput_tvalid && wd_cnt == 16'hFFFF;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd_cnt   <= '0;
      wdog_err <= 1'b0;
    end else begin
      wd_cnt <= (vinput_tvalid || in_flight == '0) ? '0 : wd_cnt + 1'b1;
      if (wdog_trip) wdog_err <= 1'b1;
    end
`else
  assign wdog_trip = 1'b0;
`endif
  a_no_orphan_result: assert property (@(posedge clk) disable iff (rst) !err);
endmodule

// File: tb/tb_vinput_sched.sv
// tb_vinput_sched: randomized environment with backbone store, fixed-latency datapath and consumer models
module tb_vinput_sched;
  localparam int J = 14, A = 2, MAX_OUT = 8, ISSUE_GAP = 12, DP_LAT = 40;
  localparam int JW = $clog2(J) + 1, AW = $clog2(A) + 1;
  typedef struct { longint due; logic [63:0] val; } dp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [J*AW-1:0] cfg_x_initial = '0;
  logic busy, done, bb_rd_en, x_initial_tvalid, ind_j_tvalid, backbone_tvalid, res_valid;
  logic [JW-1:0] bb_rd_addr, ind_j, res_j;
  logic bb_rd_valid = 0, vinput_tvalid = 0, res_ready = 0;
  logic [63:0] bb_rd_data = '0, vinput = '0, backbone, res_data;
  logic [J*AW-1:0] x_initial;
`ifdef VSCHED_WATCHDOG_EN
  logic wdog_err;
`endif
  vinput_sched dut (
    .clk(clk), .rst(rst), .start(start), .cfg_x_initial(cfg_x_initial), .busy(busy), .done(done),
    .bb_rd_en(bb_rd_en), .bb_rd_addr(bb_rd_addr), .bb_rd_valid(bb_rd_valid), .bb_rd_data(bb_rd_data),
    .x_initial(x_initial), .x_initial_tvalid(x_initial_tvalid), .ind_j(ind_j),
    .ind_j_tvalid(ind_j_tvalid), .backbone(backbone), .backbone_tvalid(backbone_tvalid),
    .vinput_tvalid(vinput_tvalid), .vinput(vinput), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_j(res_j)
`ifdef VSCHED_WATCHDOG_EN
    , .wdog_err(wdog_err)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  longint cyc = 0, last_issue = 0;
  logic [63:0] bb_mem [J];
  logic [J*AW-1:0] cfg_exp;
  int lat_max = 1, issued = 0, returned = 0, drained = 0, done_cnt = 0, xload_cnt = 0, last_fetch = 0;
  bit exact_gap = 0, rand_ready = 0, ready_fix = 1;
  logic [63:0] exp_q[$];
  int exp_jq[$];
  dp_t dq[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] dp_fn(input logic [63:0] b, input int jj);
    return b ^ (64'h9E3779B97F4A7C15 * 64'(jj + 1));
  endfunction
  // backbone store: variable read latency 1..lat_max
  initial forever begin
    int a;
    @(negedge clk);
    if (!rst && bb_rd_en) begin
      a = int'(bb_rd_addr);
      repeat ($urandom_range(lat_max, 1)) @(posedge clk);
      #1 bb_rd_data = bb_mem[a];
      bb_rd_valid = 1;
      @(posedge clk);
      #1 bb_rd_valid = 0;
    end
  end
  // datapath: fixed latency, in order, no backpressure
  initial forever begin
    @(posedge clk);
    #1 vinput_tvalid = 0;
    if (dq.size() > 0 && dq[0].due <= cyc) begin
      vinput = dq[0].val;
      vinput_tvalid = 1;
      void'(dq.pop_front());
      returned++;
    end
  end
  initial forever begin
    @(posedge clk);
    #1 res_ready = rand_ready ? 1'($urandom_range(1, 0)) : ready_fix;
  end
  // monitor and scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (x_initial_tvalid) begin
        xload_cnt++;
        chk("x_initial", 64'(x_initial), 64'(cfg_exp));
      end
      if (bb_rd_en) begin
        chk("credit", 64'(issued - drained < MAX_OUT), 64'd1);
        chk("rd_addr", 64'(bb_rd_addr), 64'(issued));
        last_fetch = int'(bb_rd_addr);
      end
      chk("tvalid_pair", 64'(ind_j_tvalid), 64'(backbone_tvalid));
      if (backbone_tvalid) begin
        chk("ind_j", 64'(ind_j), 64'(issued));
        chk("ind_j_fetch", 64'(ind_j), 64'(last_fetch));
        chk("backbone", backbone, issued < J ? bb_mem[issued] : 64'hx);
        if (issued > 0) chk("gap_min", 64'(cyc - last_issue >= ISSUE_GAP), 64'd1);
        if (issued > 0 && exact_gap) chk("gap_exact", 64'(cyc - last_issue), 64'(ISSUE_GAP));
        last_issue = cyc;
        exp_q.push_back(dp_fn(bb_mem[issued % J], issued));
        exp_jq.push_back(issued);
        dq.push_back('{cyc + DP_LAT, dp_fn(backbone, int'(ind_j))});
        issued++;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("extra_result", 64'd1, 64'd0);
        else begin
          chk("res_j", 64'(res_j), 64'(exp_jq.pop_front()));
          chk("res_data", res_data, exp_q.pop_front());
        end
        drained++;
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_returned", 64'(returned), 64'(J));
        chk("done_issued", 64'(issued), 64'(J));
      end
    end
  end
  task automatic launch(input int lm, input bit exact);
    lat_max = lm;
    exact_gap = exact;
    issued = 0; returned = 0; drained = 0; done_cnt = 0; xload_cnt = 0;
    exp_q.delete(); exp_jq.delete(); dq.delete();
    cfg_exp = (J*AW)'($urandom);
    cfg_x_initial = cfg_exp;
    foreach (bb_mem[i]) bb_mem[i] = {$urandom, $urandom};
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask
  task automatic finish_run(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin @(posedge clk); n++; end
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    n = 0;
    while (drained < J && n < 5000) begin @(posedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, "_drained"}, 64'(drained), 64'(J));
    chk({tag, "_empty"}, 64'(res_valid), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_one_load"}, 64'(xload_cnt), 64'd1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, bb_rd_en, x_initial_tvalid, ind_j_tvalid, backbone_tvalid, res_valid}), 64'd0);
    chk({tag, "_bus"}, backbone | res_data | 64'(x_initial) | 64'(ind_j) | 64'(bb_rd_addr) | 64'(res_j), 64'd0);
  endtask
  initial begin
    #2 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // nominal
    ready_fix = 1; rand_ready = 0;
    launch(1, 1);
    finish_run("nominal");
    // backpressure: consumer stalled for the whole run
    ready_fix = 0;
    launch(1, 0);
    repeat (400) @(negedge clk);
    chk("bp_issue_cap", 64'(issued), 64'(MAX_OUT));
    chk("bp_res_valid", 64'(res_valid), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    ready_fix = 1;
    finish_run("bp");
    // variable read latency with random consumer
    for (int r = 0; r < 2; r++) begin
      rand_ready = 1;
      launch(5, 0);
      finish_run("varlat");
    end
    rand_ready = 0;
    // start pulsed mid-run must be ignored
    launch(1, 1);
    begin
      int n = 0;
      while (issued < 4 && n < 2000) begin @(posedge clk); n++; end
      chk("mid_reach", 64'(issued >= 4), 64'd1);
      #1 start = 1;
      cfg_x_initial = ~cfg_exp;
      @(posedge clk);
      #1 start = 0;
    end
    finish_run("midstart");
    repeat (50) @(negedge clk);
    chk("midstart_issues", 64'(issued), 64'(J));
    // asynchronous reset during GAP of j=5
    launch(3, 0);
    begin
      int n = 0;
      while (issued < 6 && n < 2000) begin @(posedge clk); n++; end
      chk("rst_reach", 64'(issued), 64'd6);
      #1 rst = 1;
      dq.delete();
      vinput_tvalid = 0;
      #1 chk_zero("midrst");
      @(posedge clk);
      #1 rst = 0;
    end
    launch(3, 0);
    finish_run("after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vinput_sched.md
Name: vinput_sched

Overview:
- Sequencer for the backbone-to-vinput datapath: loads the initial assignment, then walks ind_j over 0..J-1.
- For each j: fetches the backbone value from the backbone store, pulses backbone_tvalid/ind_j_tvalid, and tags the returning vinput with its j.
- The datapath has no backpressure, so this block enforces issue spacing and credits. Results go into a local buffer drained by a valid/ready consumer.

Parameters:
- J, 14, number of j iterations per run
- A, 2, alternatives per j (sets x_initial width)
- MAX_OUT, 8, result buffer depth = maximum issued-but-not-drained results (power of 2)
- ISSUE_GAP, 12, minimum cycles between backbone_tvalid pulses (covers first-multiplier latency; the datapath backbone register must not be overwritten early)
- Localparams: J_WIDTH = $clog2(J)+1, A_WIDTH = $clog2(A)+1, C_WIDTH = $clog2(MAX_OUT)+1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle run request, accepted only in IDLE
- cfg_x_initial  in  J*A_WIDTH  initial assignment, sampled on accepted start
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse when the last result is written to the buffer
- bb_rd_en  out  1  backbone store read strobe
- bb_rd_addr  out  J_WIDTH  backbone store address (= current j)
- bb_rd_valid  in  1  read data valid; latency is variable, 1 or more cycles
- bb_rd_data  in  64  backbone value
- x_initial  out  J*A_WIDTH  to datapath
- x_initial_tvalid  out  1  one-cycle pulse
- ind_j  out  J_WIDTH  to datapath, held stable between pulses
- ind_j_tvalid  out  1  pulse coincident with backbone_tvalid
- backbone  out  64  to datapath
- backbone_tvalid  out  1  one-cycle issue pulse
- vinput_tvalid  in  1  datapath result valid
- vinput  in  64  datapath result
- res_valid  out  1  buffer non-empty
- res_ready  in  1  consumer accept
- res_data  out  64  head result
- res_j  out  J_WIDTH  j tag of head result

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; buffer, tag queue and counters are cleared.
- FSM states: IDLE, LOAD, FETCH, WAIT_RD, ISSUE, GAP, DRAIN, DONE.
- IDLE: start moves to LOAD. start is ignored in any other state.
- LOAD: x_initial_tvalid pulses one cycle with the captured cfg_x_initial; j is set to 0; next state FETCH.
- FETCH: waits until credit > 0, where credit = MAX_OUT - (in_flight + buf_count). Then bb_rd_en pulses with bb_rd_addr = j; next state WAIT_RD.
- WAIT_RD: on bb_rd_valid, bb_rd_data is captured; next state ISSUE.
- ISSUE: backbone_tvalid and ind_j_tvalid pulse together. in_flight increments. j is pushed to the tag queue. The gap counter is loaded with ISSUE_GAP-1; next state GAP.
- GAP: the gap counter counts down to 0.
  - If j == J-1, next state DRAIN.
  - Otherwise j increments and next state is FETCH.
  - The counter overlaps with FETCH: the next issue happens no earlier than ISSUE_GAP cycles after the previous one.
- DRAIN: waits for in_flight == 0, then goes to DONE.
- DONE: done pulses one cycle; next state IDLE. busy falls in the same cycle.
- Result path: on vinput_tvalid, {tag-queue head, vinput} is written to the buffer, the tag is popped, and in_flight decrements.
- Simultaneous issue and return in one cycle: in_flight is unchanged.
- Simultaneous buffer write and read in one cycle: buf_count is unchanged.
- Credit accounting guarantees the buffer never overflows. A vinput_tvalid with in_flight == 0 is dropped and sets a sticky internal error bit (SVA-checkable).
- The buffer is read when res_valid && res_ready. res_data and res_j are registered outputs valid whenever res_valid is high. The buffer is first-word-fall-through.
- A run finishes only after every issue has returned. The buffer may still hold undrained results after done.
- Wrap-around: buffer pointers are C_WIDTH bits; full is detected by the MSB difference.
- Reset mid-run: immediate return to IDLE; buffered and in-flight results are discarded.

Optional Feature:
- Macro: VSCHED_WATCHDOG_EN.
- With the macro: a counter restarts on each vinput_tvalid and runs while in_flight > 0. Reaching 2^16 cycles asserts the extra output wdog_err (1 bit, sticky until rst) and forces the FSM to DONE, so done still pulses.
- Without the macro: no counter and no port; DRAIN waits indefinitely.

Decomposition:
- Package vinput_sched_pkg holds:
  - FSM state enum;
  - J_WIDTH/A_WIDTH helper functions;
  - result entry struct {j, data}.
- One sub-module, vinput_sched_fifo: parameterised-width sync FWFT FIFO with count output.
  - Instantiated twice: tag queue of width J_WIDTH and result buffer of width J_WIDTH+64.

Test Plan:
- Nominal run, J=14, read latency 1, fixed datapath latency 40, res_ready always 1 -> 14 issues spaced exactly 12 cycles; res_j 0..13 in order; done after 14th write; busy low afterward.
- Backpressure: res_ready=0 for the whole run, MAX_OUT=8 -> exactly 8 issues, then FETCH stalls; raising res_ready resumes issuing; all 14 results arrive in order.
- Variable read latency 1..5 random -> issue spacing is always at least 12; ind_j equals bb_rd_addr of the same fetch.
- start pulsed mid-run -> ignored; issue count stays 14.
- Reset asserted during GAP of j=5 -> all outputs 0 asynchronously; a new start runs cleanly from j=0.
- VSCHED_WATCHDOG_EN, datapath drops result j=3 -> wdog_err=1 after 65536 idle cycles; done pulses; FSM returns to IDLE.
